// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide execute unit.
package muldiv_pkg;

    typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_DIVU, OP_REMU} op_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    // Wide all-ones value, sliced to the operand width where used.
    localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 16-bit MUL/MULH/DIVU/REMU unit; one shared add/sub per cycle,
// one register-file write per accepted operation.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [AW-1:0]    rd_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             we3_o,
    output logic [AW-1:0]    wa3_o,
    output logic [WIDTH-1:0] wd3_o
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [AW-1:0]      rd_q, rd_d;
    logic               div0_q, div0_d;
    // hi: product high half / partial remainder (extra bit keeps the borrow)
    // lo: multiplier being consumed / quotient being built
    logic [WIDTH:0]     hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [AW-1:0]      wa3_q, wa3_d;
    logic [WIDTH-1:0]   wd3_q, wd3_d;

    logic               is_mul;
    logic [WIDTH:0]     shifted, opx, opy, sum, hi_n;
    logic [WIDTH-1:0]   lo_n, result, div0_quot;

    assign div0_quot = DIV0_QUOT[WIDTH-1:0];

    always_comb begin
        is_mul  = (op_q == OP_MUL) || (op_q == OP_MULH);
        shifted = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        opx     = is_mul ? hi_q : shifted;
        opy     = (is_mul && !lo_q[0]) ? '0 : {1'b0, b_q};
        sum     = is_mul ? (opx + opy) : (opx - opy);
        if (is_mul) begin
            hi_n = {1'b0, sum[WIDTH:1]};
            lo_n = {sum[0], lo_q[WIDTH-1:1]};
        end else if (sum[WIDTH]) begin
            hi_n = shifted;
            lo_n = {lo_q[WIDTH-2:0], 1'b0};
        end else begin
            hi_n = sum;
            lo_n = {lo_q[WIDTH-2:0], 1'b1};
        end
    end

    // With b==0 every subtract succeeds, so the remainder naturally ends as a.
    always_comb begin
        case (op_q)
            OP_MUL:  result = lo_q;
            OP_MULH: result = hi_q[WIDTH-1:0];
            OP_DIVU: result = div0_q ? div0_quot : lo_q;
            default: result = hi_q[WIDTH-1:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        rd_d    = rd_q;
        div0_d  = div0_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        wa3_d   = wa3_q;
        wd3_d   = wd3_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    op_d    = op_e'(op_i);
                    b_d     = b_i;
                    rd_d    = rd_i;
                    div0_d  = (b_i == '0);
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = a_i;
                end
            end
            S_RUN: begin
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    if (rd_q != '0) begin
                        wa3_d = rd_q;
                        wd3_d = result;
                    end
                end else begin
                    hi_d  = hi_n;
                    lo_d  = lo_n;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            wa3_q   <= '0;
            wd3_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);
    assign we3_o  = done_o && (rd_q != '0);
    assign wa3_o  = wa3_q;
    assign wd3_o  = wd3_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected writes queued at accept, checked at done.
module tb_muldiv_unit;

    localparam int WIDTH = 16;
    localparam int AW    = 4;

    typedef struct {
        logic [AW-1:0]    rd;
        logic [WIDTH-1:0] data;
        int               acc_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i, b_i;
    logic [AW-1:0]    rd_i;
    logic             busy_o, done_o, we3_o;
    logic [AW-1:0]    wa3_o;
    logic [WIDTH-1:0] wd3_o;

    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t sb[$];

    muldiv_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start_i(start_i),
        .op_i   (op_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .rd_i   (rd_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .we3_o  (we3_o),
        .wa3_o  (wa3_o),
        .wd3_o  (wd3_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        case (op)
            2'd0:    return p[WIDTH-1:0];
            2'd1:    return p[2*WIDTH-1:WIDTH];
            2'd2:    return (b == 0) ? {WIDTH{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Write-port monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && (done_o || we3_o)) begin
            chk("done_with_we3", done_o, 1);
            if (sb.size() == 0) begin
                chk("sb_underflow", 0, 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("we3_en", we3_o, (e.rd != 0));
                chk("latency", cyc - e.acc_cyc, WIDTH + 1);
                if (e.rd != 0) begin
                    chk("wa3", wa3_o, e.rd);
                    chk("wd3", wd3_o, e.data);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) chk("idle_timeout", busy_o, 0);
    endtask

    // Issue one op, scramble inputs after accept, then count busy cycles.
    task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [AW-1:0] rd);
        exp_t e;
        int   n;
        wait_idle();
        start_i = 1'b1; op_i = op; a_i = a; b_i = b; rd_i = rd;
        @(negedge clk);
        e.rd = rd; e.data = model(op, a, b); e.acc_cyc = cyc;
        sb.push_back(e);
        start_i = 1'b0;
        op_i = ~op; a_i = ~a; b_i = a; rd_i = rd + 1'b1;
        n = 0;
        while (busy_o && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, WIDTH + 2);
    endtask

    initial begin
        exp_t e;
        int   n, acc0;
        rst = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; rd_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_we3", we3_o, 0);
        chk("rst_wa3", wa3_o, 0);
        chk("rst_wd3", wd3_o, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(2'd0, 16'h0123, 16'h0045, 4'd3);
        chk("hold_wa3", wa3_o, 3);
        chk("hold_wd3", wd3_o, 16'h4E6F);
        run_op(2'd1, 16'hFFFF, 16'hFFFF, 4'd5);
        run_op(2'd0, 16'hFFFF, 16'hFFFF, 4'd5);
        run_op(2'd2, 16'd1000, 16'd7, 4'd2);
        run_op(2'd3, 16'd1000, 16'd7, 4'd2);
        run_op(2'd2, 16'h1234, 16'h0000, 4'd4);
        run_op(2'd3, 16'h1234, 16'h0000, 4'd4);
        run_op(2'd0, 16'd2, 16'd3, 4'd0);
        chk("rd0_keeps_wa3", wa3_o, 4);
        for (int i = 0; i < 8; i++)
            run_op(2'(i), 16'($urandom), 16'($urandom_range(1, 300)), 4'($urandom_range(1, 15)));

        // start held high across an op: the second is accepted only after IDLE
        wait_idle();
        start_i = 1'b1; op_i = 2'd2; a_i = 16'd5000; b_i = 16'd13; rd_i = 4'd7;
        @(negedge clk);
        e.rd = 4'd7; e.data = model(2'd2, 16'd5000, 16'd13); e.acc_cyc = cyc;
        sb.push_back(e);
        acc0 = cyc;
        op_i = 2'd1; a_i = 16'hABCD; b_i = 16'h1234; rd_i = 4'd9;
        n = 0;
        while (busy_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        e.rd = 4'd9; e.data = model(2'd1, 16'hABCD, 16'h1234); e.acc_cyc = cyc;
        sb.push_back(e);
        chk("reaccept_gap", cyc - acc0, WIDTH + 3);
        chk("reaccept_busy", busy_o, 1);
        start_i = 1'b0;
        wait_idle();
        @(negedge clk);

        // reset in the middle of RUN aborts without a write
        start_i = 1'b1; op_i = 2'd0; a_i = 16'd77; b_i = 16'd88; rd_i = 4'd6;
        @(negedge clk);
        start_i = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy_o, 0);
        chk("abort_we3", we3_o, 0);
        chk("abort_done", done_o, 0);
        rst = 1'b0;
        n = 0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (we3_o || done_o) n++;
        end
        chk("abort_no_write", n, 0);
        run_op(2'd3, 16'd999, 16'd10, 4'd1);

        repeat (2) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
